// File: rtl/pingpong_bank_ctrl_if.sv
// Handshake bundle between the stream writer, the ping-pong bank controller and
// the frame reader. The controller sits on the slave modport.
interface pingpong_bank_ctrl_if #(
    parameter int ADDRBITS = 7
);
    logic                finisha;
    logic [ADDRBITS-1:0] wr_addr;
    logic                readya;
    logic                wr_bank;
    logic                rd_start;
    logic                rd_bank;
    logic [ADDRBITS:0]   rd_len;
    logic                rd_done;
    logic [1:0]          pending;
    logic                err_ovf;
    logic                err_unf;

    modport master (
        output finisha, wr_addr, rd_done,
        input  readya, wr_bank, rd_start, rd_bank, rd_len, pending, err_ovf, err_unf
    );

    modport slave (
        input  finisha, wr_addr, rd_done,
        output readya, wr_bank, rd_start, rd_bank, rd_len, pending, err_ovf, err_unf
    );
endinterface

// File: rtl/pingpong_bank_ctrl.sv
// Two-bank ping-pong scheduler: tracks bank ownership between the stream writer
// and the frame reader, and hands frames out in arrival order with their lengths.
module pingpong_bank_ctrl #(
    parameter int ADDRBITS = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    pingpong_bank_ctrl_if.slave  bus
);
    localparam logic [1:0] ST_FREE    = 2'd0;
    localparam logic [1:0] ST_FULL    = 2'd1;
    localparam logic [1:0] ST_READING = 2'd2;

    localparam logic [ADDRBITS:0] LEN_ONE = {{ADDRBITS{1'b0}}, 1'b1};

    logic [1:0][1:0]        bank_st;
    logic [1:0][1:0]        bank_nx;
    logic [1:0][ADDRBITS:0] len_q;
    logic [1:0][ADDRBITS:0] len_nx;
    logic                   wptr;
    logic                   wptr_nx;
    logic                   rptr;
    logic                   rptr_nx;

    logic                   readya_q;
    logic                   readya_nx;
    logic [1:0]             pending_q;
    logic [1:0]             pending_nx;
    logic                   rd_start_q;
    logic                   rd_bank_q;
    logic [ADDRBITS:0]      rd_len_q;
    logic                   err_ovf_q;
    logic                   err_unf_q;

    logic                   any_reading;
    logic                   wr_ok;
    logic                   wr_ovf;
    logic                   rd_ok;
    logic                   rd_unf;
    logic                   dispatch;

    // All event decisions look at registered state only, so a bank freed by
    // rd_done cannot be re-dispatched in the same cycle.
    always_comb begin
        any_reading = (bank_st[0] == ST_READING) || (bank_st[1] == ST_READING);
        wr_ok       = bus.finisha && (bank_st[wptr] == ST_FREE);
        wr_ovf      = bus.finisha && (bank_st[wptr] != ST_FREE);
        rd_ok       = bus.rd_done && (bank_st[rptr] == ST_READING);
        rd_unf      = bus.rd_done && !any_reading;
        dispatch    = !any_reading && (bank_st[rptr] == ST_FULL);
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every signal; no latches.
        bank_nx = bank_st;
        len_nx  = len_q;
        wptr_nx = wptr;
        rptr_nx = rptr;

        if (wr_ok) begin
            bank_nx[wptr] = ST_FULL;
            len_nx[wptr]  = {1'b0, bus.wr_addr} + LEN_ONE;
            wptr_nx       = ~wptr;
        end

        if (rd_ok) begin
            bank_nx[rptr] = ST_FREE;
            rptr_nx       = ~rptr;
        end

        // Dispatch excludes rd_ok (it needs no bank READING) and targets a FULL
        // bank, so it never collides with the write update above.
        if (dispatch) begin
            bank_nx[rptr] = ST_READING;
        end

        readya_nx  = (bank_nx[wptr_nx] == ST_FREE);
        pending_nx = {1'b0, bank_nx[0] == ST_FULL} + {1'b0, bank_nx[1] == ST_FULL};
    end

    // NOTE: sequential state uses non-blocking assignments only.
    // NOTE: the two length registers are plain flops and are reset with the rest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_st    <= {ST_FREE, ST_FREE};
            len_q      <= '0;
            wptr       <= 1'b0;
            rptr       <= 1'b0;
            readya_q   <= 1'b1;
            pending_q  <= 2'd0;
            rd_start_q <= 1'b0;
            rd_bank_q  <= 1'b0;
            rd_len_q   <= '0;
            err_ovf_q  <= 1'b0;
            err_unf_q  <= 1'b0;
        end else begin
            bank_st    <= bank_nx;
            len_q      <= len_nx;
            wptr       <= wptr_nx;
            rptr       <= rptr_nx;
            readya_q   <= readya_nx;
            pending_q  <= pending_nx;
            rd_start_q <= dispatch;
            if (dispatch) begin
                rd_bank_q <= rptr;
                rd_len_q  <= len_q[rptr];
            end
            if (wr_ovf) begin
                err_ovf_q <= 1'b1;
            end
            if (rd_unf) begin
                err_unf_q <= 1'b1;
            end
        end
    end

    assign bus.readya   = readya_q;
    assign bus.wr_bank  = wptr;
    assign bus.rd_start = rd_start_q;
    assign bus.rd_bank  = rd_bank_q;
    assign bus.rd_len   = rd_len_q;
    assign bus.pending  = pending_q;
    assign bus.err_ovf  = err_ovf_q;
    assign bus.err_unf  = err_unf_q;
endmodule

// File: tb/tb_pingpong_bank_ctrl.sv
// Self-checking bench for pingpong_bank_ctrl: frames pushed into a scoreboard as
// they are written, popped and compared when the controller dispatches them.
module tb_pingpong_bank_ctrl;
    localparam int AB = 7;

    typedef struct packed {
        logic          bank;
        logic [AB:0]   len;
    } disp_t;

    logic clk = 1'b0;
    logic rst;

    pingpong_bank_ctrl_if #(.ADDRBITS(AB)) bus ();

    pingpong_bank_ctrl #(.ADDRBITS(AB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    disp_t sb_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    exp_starts = 0;
    logic  m_wptr = 1'b0;

    // Passive monitor of rd_start pulses, sampled on the falling edge.
    int    mon_starts = 0;
    int    mon_back2back = 0;
    logic  prev_start = 1'b0;
    always @(negedge clk) begin
        if (bus.rd_start === 1'b1) begin
            mon_starts <= mon_starts + 1;
            if (prev_start) mon_back2back <= mon_back2back + 1;
        end
        prev_start <= (bus.rd_start === 1'b1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One-cycle finisha pulse; a frame expected to be accepted is queued.
    task automatic do_finish(input logic [AB-1:0] addr, input bit accept);
        disp_t d;
        bus.finisha = 1'b1;
        bus.wr_addr = addr;
        if (accept) begin
            d.bank = m_wptr;
            d.len  = {1'b0, addr} + 1;
            sb_q.push_back(d);
            m_wptr = ~m_wptr;
        end
        cyc();
        bus.finisha = 1'b0;
    endtask

    task automatic do_done();
        bus.rd_done = 1'b1;
        cyc();
        bus.rd_done = 1'b0;
    endtask

    // Wait for the next rd_start (expected exactly one cycle after the call) and
    // compare bank and length with the oldest queued frame.
    task automatic expect_dispatch(input string name);
        int    n;
        disp_t e;
        n = 0;
        exp_starts++;
        while (bus.rd_start !== 1'b1 && n < 6) begin
            cyc();
            n++;
        end
        n_cmp++;
        if (bus.rd_start !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_timeout rd_start got %b want 1 within 6 cycles", name, bus.rd_start);
        end else begin
            n_cmp++;
            if (n !== 1) begin
                n_bad++;
                $display("FAIL %s_latency cycles got %0d want 1", name, n);
            end
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL %s_unexpected rd_start got bank %0d want no dispatch", name, bus.rd_bank);
            end else begin
                e = sb_q.pop_front();
                n_cmp++;
                if (bus.rd_bank !== e.bank) begin
                    n_bad++;
                    $display("FAIL %s_rd_bank got %b want %b", name, bus.rd_bank, e.bank);
                end
                n_cmp++;
                if (bus.rd_len !== e.len) begin
                    n_bad++;
                    $display("FAIL %s_rd_len got %0d want %0d", name, bus.rd_len, e.len);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.finisha = 1'b0;
        bus.wr_addr = '0;
        bus.rd_done = 1'b0;
        repeat (2) cyc();
        n_cmp++;
        if ({bus.readya, bus.wr_bank, bus.rd_start, bus.rd_bank, bus.pending, bus.err_ovf, bus.err_unf} !== 8'b1000_0000) begin
            n_bad++;
            $display("FAIL reset_flags got ry%b wb%b rs%b rb%b p%0d o%b u%b want ry1 wb0 rs0 rb0 p0 o0 u0",
                     bus.readya, bus.wr_bank, bus.rd_start, bus.rd_bank, bus.pending, bus.err_ovf, bus.err_unf);
        end
        n_cmp++;
        if (bus.rd_len !== '0) begin
            n_bad++;
            $display("FAIL reset_rd_len got %0d want 0", bus.rd_len);
        end
        rst = 1'b0;
        repeat (3) cyc();
        n_cmp++;
        if (bus.readya !== 1'b1 || bus.rd_start !== 1'b0 || bus.pending !== 2'd0 || bus.wr_bank !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_outputs got ry%b rs%b p%0d wb%b want ry1 rs0 p0 wb0",
                     bus.readya, bus.rd_start, bus.pending, bus.wr_bank);
        end
    endtask

    task automatic test_single_frame();
        do_finish(7'd127, 1'b1);
        n_cmp++;
        if (bus.wr_bank !== 1'b1 || bus.readya !== 1'b1 || bus.pending !== 2'd1 || bus.rd_start !== 1'b0) begin
            n_bad++;
            $display("FAIL single_after_finish got wb%b ry%b p%0d rs%b want wb1 ry1 p1 rs0",
                     bus.wr_bank, bus.readya, bus.pending, bus.rd_start);
        end
        expect_dispatch("single");
        cyc();
        n_cmp++;
        if (bus.rd_start !== 1'b0) begin
            n_bad++;
            $display("FAIL single_pulse_width rd_start got %b want 0", bus.rd_start);
        end
        do_done();
        n_cmp++;
        if (bus.pending !== 2'd0 || bus.err_unf !== 1'b0) begin
            n_bad++;
            $display("FAIL single_done got p%0d u%b want p0 u0", bus.pending, bus.err_unf);
        end
    endtask

    task automatic test_short_frame();
        do_finish(7'd9, 1'b1);
        expect_dispatch("short");
        do_done();
    endtask

    task automatic test_back_pressure();
        int starts_before;
        do_finish(7'd20, 1'b1);
        expect_dispatch("bp_first");
        do_finish(7'd30, 1'b1);
        n_cmp++;
        if (bus.readya !== 1'b0 || bus.pending !== 2'd1 || bus.wr_bank !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_full got ry%b p%0d wb%b want ry0 p1 wb0", bus.readya, bus.pending, bus.wr_bank);
        end
        starts_before = mon_starts;
        repeat (3) cyc();
        n_cmp++;
        if (mon_starts !== starts_before) begin
            n_bad++;
            $display("FAIL bp_hold rd_start pulses got %0d want 0 while reading", mon_starts - starts_before);
        end
        do_done();
        n_cmp++;
        if (bus.readya !== 1'b1 || bus.wr_bank !== 1'b0 || bus.pending !== 2'd1 || bus.rd_start !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_release got ry%b wb%b p%0d rs%b want ry1 wb0 p1 rs0",
                     bus.readya, bus.wr_bank, bus.pending, bus.rd_start);
        end
        expect_dispatch("bp_second");
        do_done();
    endtask

    task automatic test_simultaneous();
        disp_t d;
        do_finish(7'd40, 1'b1);
        expect_dispatch("sim_first");
        d.bank = m_wptr;
        d.len  = 8'd64;
        sb_q.push_back(d);
        m_wptr = ~m_wptr;
        bus.rd_done = 1'b1;
        bus.finisha = 1'b1;
        bus.wr_addr = 7'd63;
        cyc();
        bus.rd_done = 1'b0;
        bus.finisha = 1'b0;
        n_cmp++;
        if (bus.err_ovf !== 1'b0 || bus.err_unf !== 1'b0 || bus.pending !== 2'd1 ||
            bus.readya !== 1'b1 || bus.wr_bank !== 1'b0) begin
            n_bad++;
            $display("FAIL sim_state got o%b u%b p%0d ry%b wb%b want o0 u0 p1 ry1 wb0",
                     bus.err_ovf, bus.err_unf, bus.pending, bus.readya, bus.wr_bank);
        end
        expect_dispatch("sim_second");
        do_done();
    endtask

    task automatic test_errors();
        do_finish(7'd5, 1'b1);
        expect_dispatch("err_first");
        do_finish(7'd7, 1'b1);
        do_finish(7'd99, 1'b0);
        n_cmp++;
        if (bus.err_ovf !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_flag got %b want 1", bus.err_ovf);
        end
        n_cmp++;
        if (bus.pending !== 2'd1 || bus.rd_len !== 8'd6 || bus.rd_bank !== 1'b0 ||
            bus.wr_bank !== 1'b0 || bus.readya !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_no_change got p%0d len%0d rb%b wb%b ry%b want p1 len6 rb0 wb0 ry0",
                     bus.pending, bus.rd_len, bus.rd_bank, bus.wr_bank, bus.readya);
        end
        do_done();
        expect_dispatch("err_after_ovf");
        do_done();
        n_cmp++;
        if (bus.err_unf !== 1'b0) begin
            n_bad++;
            $display("FAIL unf_early got %b want 0", bus.err_unf);
        end
        do_done();
        n_cmp++;
        if (bus.err_unf !== 1'b1 || bus.pending !== 2'd0) begin
            n_bad++;
            $display("FAIL unf_flag got u%b p%0d want u1 p0", bus.err_unf, bus.pending);
        end
        repeat (4) cyc();
        n_cmp++;
        if (bus.err_ovf !== 1'b1 || bus.err_unf !== 1'b1) begin
            n_bad++;
            $display("FAIL err_sticky got o%b u%b want o1 u1", bus.err_ovf, bus.err_unf);
        end
    endtask

    task automatic test_reset_mid_frame();
        do_finish(7'd50, 1'b1);
        n_cmp++;
        if (bus.pending !== 2'd1 || bus.wr_bank !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_pre got p%0d wb%b want p1 wb1", bus.pending, bus.wr_bank);
        end
        rst = 1'b1;
        #2;
        n_cmp++;
        if ({bus.readya, bus.wr_bank, bus.rd_start, bus.rd_bank, bus.pending, bus.err_ovf, bus.err_unf} !== 8'b1000_0000) begin
            n_bad++;
            $display("FAIL mid_reset_flags got ry%b wb%b rs%b rb%b p%0d o%b u%b want ry1 wb0 rs0 rb0 p0 o0 u0",
                     bus.readya, bus.wr_bank, bus.rd_start, bus.rd_bank, bus.pending, bus.err_ovf, bus.err_unf);
        end
        n_cmp++;
        if (bus.rd_len !== '0) begin
            n_bad++;
            $display("FAIL mid_reset_rd_len got %0d want 0", bus.rd_len);
        end
        sb_q.delete();
        m_wptr = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        do_finish(7'd9, 1'b1);
        expect_dispatch("post_reset");
        do_done();
    endtask

    task automatic test_final();
        repeat (2) cyc();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_leftover frames got %0d want 0", sb_q.size());
        end
        n_cmp++;
        if (mon_starts != exp_starts) begin
            n_bad++;
            $display("FAIL start_count got %0d want %0d", mon_starts, exp_starts);
        end
        n_cmp++;
        if (mon_back2back != 0) begin
            n_bad++;
            $display("FAIL back_to_back_starts got %0d want 0", mon_back2back);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_short_frame();
        test_back_pressure();
        test_simultaneous();
        test_errors();
        test_reset_mid_frame();
        test_final();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
